// File: rtl/axi_lite_sram_frontend_pkg.sv
// Shared types and constants for the AXI4-Lite SRAM front-end.
//   wr_state_e / rd_state_e : write and read channel FSM states
//   RESP_OKAY / RESP_DECERR : AXI response codes driven on B/R
package sram_axi_pkg;

   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_PUSH   = 2'd1,
      WR_WAIT_B = 2'd2,
      WR_RESP   = 2'd3
   } wr_state_e;

   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_PUSH   = 2'd1,
      RD_WAIT_R = 2'd2,
      RD_RESP   = 2'd3
   } rd_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_sram_frontend_if.sv
// AXI4-Lite bus bundle between the CPU-side master and the SRAM front-end.
//   AW: s_axi_awaddr/awvalid/awready   W: s_axi_wdata/wstrb/wvalid/wready
//   B : s_axi_bresp/bvalid/bready      AR: s_axi_araddr/arvalid/arready
//   R : s_axi_rdata/rresp/rvalid/rready
//   modport slave  : the front-end side
//   modport master : the requester side (bench or interconnect)
interface axi_lite_sram_frontend_if #(
   parameter int unsigned AXI_ADDR_WIDTH  = 32,
   parameter int unsigned SRAM_DATA_WIDTH = 32
);
   localparam int unsigned STRB_W = SRAM_DATA_WIDTH / 8;

   logic [AXI_ADDR_WIDTH-1:0]  s_axi_awaddr;
   logic                       s_axi_awvalid;
   logic                       s_axi_awready;
   logic [SRAM_DATA_WIDTH-1:0] s_axi_wdata;
   logic [STRB_W-1:0]          s_axi_wstrb;
   logic                       s_axi_wvalid;
   logic                       s_axi_wready;
   logic [1:0]                 s_axi_bresp;
   logic                       s_axi_bvalid;
   logic                       s_axi_bready;
   logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr;
   logic                       s_axi_arvalid;
   logic                       s_axi_arready;
   logic [SRAM_DATA_WIDTH-1:0] s_axi_rdata;
   logic [1:0]                 s_axi_rresp;
   logic                       s_axi_rvalid;
   logic                       s_axi_rready;

   modport slave (
      input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
      output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );

   modport master (
      output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
      input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );

endinterface

// File: rtl/axi_lite_sram_frontend.sv
// AXI4-Lite slave front-end for the SRAM subsystem (single axi_clk domain).
// Converts AW/W/AR into word-address / {strb,data} pushes on the request
// FIFOs and turns b/r FIFO pops into B/R responses. One write and one read
// may be outstanding at a time; the two paths are fully independent.
// Ports:
//   axi_clk, axi_rst_n          clock, async active-low reset
//   s_axi                       AXI4-Lite slave bundle
//   aw_fifo_wdata/wen/full      write word-address request FIFO
//   w_fifo_wdata/wen/full       write {strb, data} FIFO (strb in MSBs)
//   ar_fifo_wdata/wen/full      read word-address request FIFO
//   r_fifo_rdata/ren/empty      FWFT read data FIFO
//   b_fifo_rdata/ren/empty      FWFT write response FIFO
// FIFO wen/ren are single-cycle strobes decoded from the FSM state and the
// FIFO flags so a push/pop lands in the same cycle the FIFO allows it.
// Build option: define SRAM_FRONTEND_ADDR_CHECK_EN to answer accesses beyond
// the SRAM word range with DECERR instead of forwarding them.
module axi_lite_sram_frontend #(
   parameter int unsigned AXI_ADDR_WIDTH  = 32,
   parameter int unsigned SRAM_ADDR_WIDTH = 16,
   parameter int unsigned SRAM_DATA_WIDTH = 32
) (
   input  logic                                         axi_clk,
   input  logic                                         axi_rst_n,
   axi_lite_sram_frontend_if.slave                      s_axi,
   output logic [AXI_ADDR_WIDTH-1:0]                    aw_fifo_wdata,
   output logic                                         aw_fifo_wen,
   input  logic                                         aw_fifo_full,
   output logic [SRAM_DATA_WIDTH+SRAM_DATA_WIDTH/8-1:0] w_fifo_wdata,
   output logic                                         w_fifo_wen,
   input  logic                                         w_fifo_full,
   output logic [AXI_ADDR_WIDTH-1:0]                    ar_fifo_wdata,
   output logic                                         ar_fifo_wen,
   input  logic                                         ar_fifo_full,
   input  logic [SRAM_DATA_WIDTH-1:0]                   r_fifo_rdata,
   output logic                                         r_fifo_ren,
   input  logic                                         r_fifo_empty,
   input  logic [1:0]                                   b_fifo_rdata,
   output logic                                         b_fifo_ren,
   input  logic                                         b_fifo_empty
);
   import sram_axi_pkg::*;

   localparam int unsigned STRB_W   = SRAM_DATA_WIDTH / 8;
   localparam int unsigned ALSB     = $clog2(STRB_W);
   localparam int unsigned W_FIFO_W = SRAM_DATA_WIDTH + STRB_W;

`ifdef SRAM_FRONTEND_ADDR_CHECK_EN
   localparam bit ADDR_CHECK = 1'b1;
`else
   localparam bit ADDR_CHECK = 1'b0;
`endif

   // Byte address to word address; byte-offset bits are dropped
   function automatic logic [AXI_ADDR_WIDTH-1:0] word_addr(input logic [AXI_ADDR_WIDTH-1:0] a);
      return a >> ALSB;
   endfunction

   // Word address outside the SRAM array
   function automatic logic addr_bad(input logic [AXI_ADDR_WIDTH-1:0] wa);
      return (wa >> SRAM_ADDR_WIDTH) != '0;
   endfunction

   // ---------------------------------------------------------------- write path
   wr_state_e                  wr_state,  wr_state_n;
   logic                       aw_held,   aw_held_n;
   logic                       w_held,    w_held_n;
   logic [AXI_ADDR_WIDTH-1:0]  waddr_q,   waddr_n;
   logic [W_FIFO_W-1:0]        wpay_q,    wpay_n;
   logic                       awready_q, awready_n;
   logic                       wready_q,  wready_n;
   logic                       bvalid_q,  bvalid_n;
   logic [1:0]                 bresp_q,   bresp_n;

   // Write FSM state and output registers
   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         wr_state  <= WR_IDLE;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         waddr_q   <= '0;
         wpay_q    <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         wr_state  <= wr_state_n;
         aw_held   <= aw_held_n;
         w_held    <= w_held_n;
         waddr_q   <= waddr_n;
         wpay_q    <= wpay_n;
         awready_q <= awready_n;
         wready_q  <= wready_n;
         bvalid_q  <= bvalid_n;
         bresp_q   <= bresp_n;
      end
   end

   // Write FSM next-state and FIFO strobes
   always_comb begin
      wr_state_n  = wr_state;
      aw_held_n   = aw_held;
      w_held_n    = w_held;
      waddr_n     = waddr_q;
      wpay_n      = wpay_q;
      bvalid_n    = bvalid_q;
      bresp_n     = bresp_q;
      aw_fifo_wen = 1'b0;
      w_fifo_wen  = 1'b0;
      b_fifo_ren  = 1'b0;

      case (wr_state)
         WR_IDLE: begin
            if (s_axi.s_axi_awvalid && awready_q) begin
               aw_held_n = 1'b1;
               waddr_n   = word_addr(s_axi.s_axi_awaddr);
            end
            if (s_axi.s_axi_wvalid && wready_q) begin
               w_held_n = 1'b1;
               wpay_n   = {s_axi.s_axi_wstrb, s_axi.s_axi_wdata};
            end
            // Held flags are consumed here so they are clear on return to IDLE
            if (aw_held_n && w_held_n) begin
               aw_held_n = 1'b0;
               w_held_n  = 1'b0;
               if (ADDR_CHECK && addr_bad(waddr_n)) begin
                  bvalid_n   = 1'b1;
                  bresp_n    = RESP_DECERR;
                  wr_state_n = WR_RESP;
               end else begin
                  wr_state_n = WR_PUSH;
               end
            end
         end
         WR_PUSH: begin
            if (!aw_fifo_full && !w_fifo_full) begin
               aw_fifo_wen = 1'b1;
               w_fifo_wen  = 1'b1;
               wr_state_n  = WR_WAIT_B;
            end
         end
         WR_WAIT_B: begin
            if (!b_fifo_empty) begin
               b_fifo_ren = 1'b1;
               bresp_n    = b_fifo_rdata;
               bvalid_n   = 1'b1;
               wr_state_n = WR_RESP;
            end
         end
         WR_RESP: begin
            if (s_axi.s_axi_bready) begin
               bvalid_n   = 1'b0;
               wr_state_n = WR_IDLE;
            end
         end
         default: wr_state_n = WR_IDLE;
      endcase

      // Ready is registered from the next state, so never a comb path from valid
      awready_n = (wr_state_n == WR_IDLE) && !aw_held_n;
      wready_n  = (wr_state_n == WR_IDLE) && !w_held_n;
   end

   assign s_axi.s_axi_awready = awready_q;
   assign s_axi.s_axi_wready  = wready_q;
   assign s_axi.s_axi_bvalid  = bvalid_q;
   assign s_axi.s_axi_bresp   = bresp_q;
   assign aw_fifo_wdata       = waddr_q;
   assign w_fifo_wdata        = wpay_q;

   // ----------------------------------------------------------------- read path
   rd_state_e                  rd_state,  rd_state_n;
   logic [AXI_ADDR_WIDTH-1:0]  raddr_q,   raddr_n;
   logic                       arready_q, arready_n;
   logic                       rvalid_q,  rvalid_n;
   logic [SRAM_DATA_WIDTH-1:0] rdata_q,   rdata_n;
   logic [1:0]                 rresp_q,   rresp_n;

   // Read FSM state and output registers
   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         rd_state  <= RD_IDLE;
         raddr_q   <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         rd_state  <= rd_state_n;
         raddr_q   <= raddr_n;
         arready_q <= arready_n;
         rvalid_q  <= rvalid_n;
         rdata_q   <= rdata_n;
         rresp_q   <= rresp_n;
      end
   end

   // Read FSM next-state and FIFO strobes
   always_comb begin
      rd_state_n  = rd_state;
      raddr_n     = raddr_q;
      rvalid_n    = rvalid_q;
      rdata_n     = rdata_q;
      rresp_n     = rresp_q;
      ar_fifo_wen = 1'b0;
      r_fifo_ren  = 1'b0;

      case (rd_state)
         RD_IDLE: begin
            if (s_axi.s_axi_arvalid && arready_q) begin
               raddr_n = word_addr(s_axi.s_axi_araddr);
               if (ADDR_CHECK && addr_bad(raddr_n)) begin
                  rvalid_n   = 1'b1;
                  rdata_n    = '0;
                  rresp_n    = RESP_DECERR;
                  rd_state_n = RD_RESP;
               end else begin
                  rd_state_n = RD_PUSH;
               end
            end
         end
         RD_PUSH: begin
            if (!ar_fifo_full) begin
               ar_fifo_wen = 1'b1;
               rd_state_n  = RD_WAIT_R;
            end
         end
         RD_WAIT_R: begin
            if (!r_fifo_empty) begin
               r_fifo_ren = 1'b1;
               rdata_n    = r_fifo_rdata;
               rresp_n    = RESP_OKAY;
               rvalid_n   = 1'b1;
               rd_state_n = RD_RESP;
            end
         end
         RD_RESP: begin
            if (s_axi.s_axi_rready) begin
               rvalid_n   = 1'b0;
               rd_state_n = RD_IDLE;
            end
         end
         default: rd_state_n = RD_IDLE;
      endcase

      arready_n = (rd_state_n == RD_IDLE);
   end

   assign s_axi.s_axi_arready = arready_q;
   assign s_axi.s_axi_rvalid  = rvalid_q;
   assign s_axi.s_axi_rdata   = rdata_q;
   assign s_axi.s_axi_rresp   = rresp_q;
   assign ar_fifo_wdata       = raddr_q;

endmodule

// File: tb/tb_axi_lite_sram_frontend.sv
// Self-checking bench for axi_lite_sram_frontend. The bench acts as the AXI
// master and as the five FIFOs; every push is logged with its cycle number and
// compared against the expected word address / payload / timing.
`timescale 1ns/1ps
module tb_axi_lite_sram_frontend;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] aw_fifo_wdata;
   logic          aw_fifo_wen, aw_fifo_full;
   logic [DW+SW-1:0] w_fifo_wdata;
   logic          w_fifo_wen, w_fifo_full;
   logic [AW-1:0] ar_fifo_wdata;
   logic          ar_fifo_wen, ar_fifo_full;
   logic [DW-1:0] r_fifo_rdata;
   logic          r_fifo_ren, r_fifo_empty;
   logic [1:0]    b_fifo_rdata;
   logic          b_fifo_ren, b_fifo_empty;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int viol  = 0;

   typedef struct {
      int          cyc;
      logic [63:0] data;
   } push_t;
   push_t aw_q[$];
   push_t w_q[$];
   push_t ar_q[$];

   axi_lite_sram_frontend_if #(.AXI_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW)) s_axi ();

   axi_lite_sram_frontend #(
      .AXI_ADDR_WIDTH(AW), .SRAM_ADDR_WIDTH(16), .SRAM_DATA_WIDTH(DW)
   ) dut (
      .axi_clk(clk), .axi_rst_n(rst_n), .s_axi(s_axi),
      .aw_fifo_wdata(aw_fifo_wdata), .aw_fifo_wen(aw_fifo_wen), .aw_fifo_full(aw_fifo_full),
      .w_fifo_wdata(w_fifo_wdata), .w_fifo_wen(w_fifo_wen), .w_fifo_full(w_fifo_full),
      .ar_fifo_wdata(ar_fifo_wdata), .ar_fifo_wen(ar_fifo_wen), .ar_fifo_full(ar_fifo_full),
      .r_fifo_rdata(r_fifo_rdata), .r_fifo_ren(r_fifo_ren), .r_fifo_empty(r_fifo_empty),
      .b_fifo_rdata(b_fifo_rdata), .b_fifo_ren(b_fifo_ren), .b_fifo_empty(b_fifo_empty)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [13:0] ctl_outs;
   assign ctl_outs = {s_axi.s_axi_awready, s_axi.s_axi_wready, s_axi.s_axi_bvalid, s_axi.s_axi_bresp,
                      s_axi.s_axi_arready, s_axi.s_axi_rvalid, s_axi.s_axi_rresp,
                      aw_fifo_wen, w_fifo_wen, ar_fifo_wen, b_fifo_ren, r_fifo_ren};

   // FIFO-side log of pushes, plus protocol violations (push when full, pop when empty)
   always @(negedge clk) begin
      if (aw_fifo_wen) aw_q.push_back('{cyc, 64'(aw_fifo_wdata)});
      if (w_fifo_wen)  w_q.push_back('{cyc, 64'(w_fifo_wdata)});
      if (ar_fifo_wen) ar_q.push_back('{cyc, 64'(ar_fifo_wdata)});
      if ((aw_fifo_wen && aw_fifo_full) || (w_fifo_wen && w_fifo_full) ||
          (ar_fifo_wen && ar_fifo_full) || (b_fifo_ren && b_fifo_empty) ||
          (r_fifo_ren && r_fifo_empty))
         viol++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference rule: word address beyond 2**16 words is rejected only in the checking build
   function automatic bit addr_bad(input logic [31:0] a);
`ifdef SRAM_FRONTEND_ADDR_CHECK_EN
      return (a >> 2) >= 32'h0001_0000;
`else
      return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
   endfunction

   function automatic logic [31:0] rand_addr();
      return ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & 32'h0003_FFFF);
   endfunction

   task automatic wr_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int aw_dly, input int w_dly, input int full_cyc,
                         input logic [1:0] bresp_in, input int b_dly, input int bready_dly);
      bit aw_done, w_done, bad, found;
      int n, a0, w0, exp_cyc;
      push_t ea, ew;
      logic [1:0] exp_resp;
      bad = addr_bad(addr);
      a0 = aw_q.size();
      w0 = w_q.size();
      aw_done = 0; w_done = 0; n = 0;
      s_axi.s_axi_awaddr = addr;
      s_axi.s_axi_wdata  = data;
      s_axi.s_axi_wstrb  = strb;
      while (!(aw_done && w_done) && n < 60) begin
         s_axi.s_axi_awvalid = !aw_done && (n >= aw_dly);
         s_axi.s_axi_wvalid  = !w_done && (n >= w_dly);
         @(negedge clk);
         if (s_axi.s_axi_awvalid && s_axi.s_axi_awready) aw_done = 1;
         if (s_axi.s_axi_wvalid && s_axi.s_axi_wready) w_done = 1;
         @(posedge clk); #1;
         n++;
         if (w_done && !aw_done) check("wr_wready_low", 64'(s_axi.s_axi_wready), 64'(0));
         if (aw_done && !w_done) check("wr_awready_low", 64'(s_axi.s_axi_awready), 64'(0));
      end
      s_axi.s_axi_awvalid = 0;
      s_axi.s_axi_wvalid  = 0;
      check("wr_handshake", 64'({aw_done, w_done}), 64'(2'b11));
      if (bad) begin
         exp_resp = 2'b11;
      end else begin
         for (int i = 0; i < full_cyc; i++) begin
            aw_fifo_full = (i % 2 == 0);
            w_fifo_full  = (i % 2 == 1);
            @(negedge clk);
            check("wr_full_stall", 64'({aw_fifo_wen, w_fifo_wen, s_axi.s_axi_awready, s_axi.s_axi_wready}), 64'(0));
            @(posedge clk); #1;
         end
         aw_fifo_full = 0;
         w_fifo_full  = 0;
         exp_cyc = cyc;
         found = 0; n = 0;
         while (!found && n < 20) begin
            @(negedge clk); #1;
            found = (aw_q.size() > a0) && (w_q.size() > w0);
            n++;
         end
         check("wr_push_seen", 64'(found), 64'(1));
         if (found) begin
            ea = aw_q.pop_front();
            ew = w_q.pop_front();
            check("wr_aw_word", ea.data, 64'(addr >> 2));
            check("wr_w_payload", ew.data, 64'({strb, data}));
            check("wr_aw_push_cycle", 64'(ea.cyc), 64'(exp_cyc));
            check("wr_w_push_cycle", 64'(ew.cyc), 64'(exp_cyc));
         end
         if (b_dly < 0) return;
         repeat (b_dly) @(posedge clk);
         @(posedge clk); #1;
         b_fifo_rdata = bresp_in;
         b_fifo_empty = 0;
         @(negedge clk);
         check("wr_b_pop", 64'(b_fifo_ren), 64'(1));
         @(posedge clk); #1;
         b_fifo_empty = 1;
         b_fifo_rdata = 2'($urandom);
         exp_resp = bresp_in;
      end
      check("wr_bvalid", 64'(s_axi.s_axi_bvalid), 64'(1));
      check("wr_bresp", 64'(s_axi.s_axi_bresp), 64'(exp_resp));
      for (int i = 0; i < bready_dly; i++) begin
         @(posedge clk); #1;
         check("wr_b_hold", 64'({s_axi.s_axi_bvalid, s_axi.s_axi_bresp}), 64'({1'b1, exp_resp}));
      end
      s_axi.s_axi_bready = 1;
      @(posedge clk); #1;
      s_axi.s_axi_bready = 0;
      check("wr_b_done", 64'(s_axi.s_axi_bvalid), 64'(0));
      check("wr_push_count", 64'(aw_q.size() + w_q.size()), 64'(a0 + w0));
   endtask

   task automatic rd_txn(input logic [31:0] addr, input logic [31:0] rd, input int ar_dly,
                         input int full_cyc, input int r_dly, input int rready_dly);
      bit done, bad, found;
      int n, q0, exp_cyc;
      push_t ea;
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
      bad = addr_bad(addr);
      q0 = ar_q.size();
      repeat (ar_dly) begin @(posedge clk); #1; end
      s_axi.s_axi_araddr  = addr;
      s_axi.s_axi_arvalid = 1;
      done = 0; n = 0;
      while (!done && n < 60) begin
         @(negedge clk);
         done = s_axi.s_axi_arready;
         @(posedge clk); #1;
         n++;
      end
      s_axi.s_axi_arvalid = 0;
      check("rd_handshake", 64'(done), 64'(1));
      if (bad) begin
         exp_d = 32'h0;
         exp_r = 2'b11;
      end else begin
         for (int i = 0; i < full_cyc; i++) begin
            ar_fifo_full = 1;
            @(negedge clk);
            check("rd_full_stall", 64'({ar_fifo_wen, s_axi.s_axi_arready}), 64'(0));
            @(posedge clk); #1;
         end
         ar_fifo_full = 0;
         exp_cyc = cyc;
         found = 0; n = 0;
         while (!found && n < 20) begin
            @(negedge clk); #1;
            found = ar_q.size() > q0;
            n++;
         end
         check("rd_push_seen", 64'(found), 64'(1));
         if (found) begin
            ea = ar_q.pop_front();
            check("rd_ar_word", ea.data, 64'(addr >> 2));
            check("rd_push_cycle", 64'(ea.cyc), 64'(exp_cyc));
         end
         repeat (r_dly) @(posedge clk);
         @(posedge clk); #1;
         r_fifo_rdata = rd;
         r_fifo_empty = 0;
         @(negedge clk);
         check("rd_r_pop", 64'(r_fifo_ren), 64'(1));
         @(posedge clk); #1;
         r_fifo_empty = 1;
         r_fifo_rdata = $urandom;
         exp_d = rd;
         exp_r = 2'b00;
      end
      check("rd_rvalid", 64'(s_axi.s_axi_rvalid), 64'(1));
      check("rd_rdata", 64'(s_axi.s_axi_rdata), 64'(exp_d));
      check("rd_rresp", 64'(s_axi.s_axi_rresp), 64'(exp_r));
      for (int i = 0; i < rready_dly; i++) begin
         @(posedge clk); #1;
         check("rd_hold", 64'({s_axi.s_axi_rvalid, s_axi.s_axi_rresp, s_axi.s_axi_rdata}),
               64'({1'b1, exp_r, exp_d}));
      end
      s_axi.s_axi_rready = 1;
      @(posedge clk); #1;
      s_axi.s_axi_rready = 0;
      check("rd_done", 64'(s_axi.s_axi_rvalid), 64'(0));
      check("rd_push_count", 64'(ar_q.size()), 64'(q0));
   endtask

   initial begin
      logic [31:0] wa, ra;
      rst_n = 0;
      s_axi.s_axi_awaddr = '0; s_axi.s_axi_awvalid = 0;
      s_axi.s_axi_wdata  = '0; s_axi.s_axi_wstrb = '0; s_axi.s_axi_wvalid = 0;
      s_axi.s_axi_bready = 0;
      s_axi.s_axi_araddr = '0; s_axi.s_axi_arvalid = 0; s_axi.s_axi_rready = 0;
      aw_fifo_full = 0; w_fifo_full = 0; ar_fifo_full = 0;
      r_fifo_rdata = '0; r_fifo_empty = 1;
      b_fifo_rdata = '0; b_fifo_empty = 1;
      repeat (3) @(posedge clk); #1;
      check("rst_ctl", 64'(ctl_outs), 64'(0));
      check("rst_rdata", 64'(s_axi.s_axi_rdata), 64'(0));
      rst_n = 1;
      repeat (2) @(posedge clk); #1;
      check("idle_ready", 64'({s_axi.s_axi_awready, s_axi.s_axi_wready, s_axi.s_axi_arready}), 64'(3'b111));

      // AW and W together
      wr_txn(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 0, 0);
      // W two cycles ahead of AW
      wr_txn(32'h0000_0044, 32'hCAFE_F00D, 4'h5, 2, 0, 0, 2'b10, 1, 2);
      // AW ahead of W, with FIFO-full stalls
      wr_txn(32'h0000_5678, 32'h0BAD_F00D, 4'h3, 0, 3, 4, 2'b00, 2, 1);
      // Read with rready held off for 5 cycles
      rd_txn(32'h0000_0020, 32'h1234_5678, 0, 0, 0, 5);
      // ar FIFO full for 10 cycles
      rd_txn(32'h0000_0104, 32'hA5A5_5A5A, 1, 10, 1, 0);
      // Concurrent write and read, responses returning in the same cycle
      fork
         wr_txn(32'h0000_0080, 32'h1111_2222, 4'hC, 0, 0, 0, 2'b00, 0, 1);
         rd_txn(32'h0000_0090, 32'h3333_4444, 0, 0, 0, 3);
      join
      // First word beyond a 64K-word SRAM
      rd_txn(32'h0004_0000, 32'h5555_AAAA, 0, 0, 0, 1);
      wr_txn(32'h0004_0000, 32'h6666_7777, 4'hF, 0, 0, 0, 2'b00, 0, 1);
      // Last in-range word
      rd_txn(32'h0003_FFFC, 32'h0F0F_F0F0, 0, 0, 0, 0);

      for (int i = 0; i < 24; i++) begin
         wa = rand_addr();
         ra = rand_addr();
         fork
            wr_txn(wa, 32'($urandom), 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 2'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            rd_txn(ra, 32'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         join
      end

      // Reset asserted while the write waits for its response
      wr_txn(32'h0000_0030, 32'h0000_0077, 4'h1, 0, 0, 0, 2'b00, -1, 0);
      @(posedge clk); #1;
      b_fifo_rdata = 2'b10;
      b_fifo_empty = 0;
      #1;
      check("wait_b_ren", 64'(b_fifo_ren), 64'(1));
      rst_n = 0;
      #1;
      check("rst_async_ctl", 64'(ctl_outs), 64'(0));
      check("rst_async_rdata", 64'(s_axi.s_axi_rdata), 64'(0));
      @(posedge clk); #1;
      b_fifo_empty = 1;
      rst_n = 1;
      repeat (3) @(posedge clk); #1;
      check("rst_dropped_txn", 64'({s_axi.s_axi_bvalid, s_axi.s_axi_awready, s_axi.s_axi_wready, s_axi.s_axi_arready}),
            64'(4'b0111));
      wr_txn(32'h0000_0008, 32'h89AB_CDEF, 4'h9, 1, 0, 0, 2'b00, 0, 0);

      check("fifo_protocol", 64'(viol), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
